timer_counter: RTL and testbench

- Memory-mapped countdown timer on the CPU data bus, downstream of the mips_cpu m_data_* port and alongside data memory.
- Decodes its address window, takes the same byte-enabled stores the data memory takes, and returns read data combinationally.
- Counts down from a preset value and raises an interrupt request for the CPU exception logic.

---
 rtl/timer_counter.sv | 240 ++++++++++++++++++++++++
 tb/tb_timer_counter.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/timer_counter.sv
// timer_counter: memory-mapped countdown timer for the CPU data bus.
//
// Register window (16 bytes at BASE, selected by addr[3:2]):
//   0x0 CTRL   bit0 EN, bits[2:1] MODE (01 = auto-reload, else one-shot), bit3 IM
//   0x4 PRESET read/write
//   0x8 COUNT  read-only
//   0xC        reads 0, writes ignored
// Stores use the same byte enables as data memory; reads are combinational.
//
// Optional build macro TC_PRESCALE_EN: when defined, an 8-bit prescaler
// divides the count rate by PRESCALE. When undefined, the count steps every cycle.
//
// Bus handshake: there is no valid/ready pair. A store is addr in the window
// with byteen != 0, and it commits on the rising edge of clk. A read is
// always accepted: rdata follows addr in the same cycle.
module timer_counter #(
    parameter logic [31:0] BASE     = 32'h0000_7F00,
    parameter int unsigned PRESCALE = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] addr,
    input  logic [3:0]  byteen,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        hit,
    output logic        irq
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_CNT  = 2'd2,
        ST_INT  = 2'd3
    } state_t;

    localparam logic [1:0] OFF_CTRL   = 2'd0;
    localparam logic [1:0] OFF_PRESET = 2'd1;
    localparam logic [1:0] OFF_COUNT  = 2'd2;
    localparam logic [1:0] OFF_RSVD   = 2'd3;

    state_t      state_q, state_d;
    logic [3:0]  ctrl_q, ctrl_d;
    logic [31:0] preset_q, preset_d;
    logic [31:0] count_q, count_d;
    logic        irq_flag_q, irq_flag_d;
    logic        irq_q, irq_d;

    // Decoded CTRL fields.
    logic       ctrl_en;
    logic [1:0] ctrl_mode;
    logic       ctrl_im;
    logic       reload_mode;

    assign ctrl_en     = ctrl_q[0];
    assign ctrl_mode   = ctrl_q[2:1];
    assign ctrl_im     = ctrl_q[3];
    assign reload_mode = (ctrl_mode == 2'b01);

    // Address decode and store strobes.
    logic wr_en;
    logic wr_ctrl;
    logic wr_preset;

    assign hit       = (addr[31:4] == BASE[31:4]);
    assign wr_en     = hit && (byteen != 4'b0000);
    assign wr_ctrl   = wr_en && (addr[3:2] == OFF_CTRL);
    assign wr_preset = wr_en && (addr[3:2] == OFF_PRESET);

    // Byte-lane addressing only; the low address bits carry no register select.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[1:0];

    // Requests from the FSM to the register-update logic.
    logic fsm_set_flag;
    logic fsm_clr_flag;
    logic fsm_clr_en;

    // step_tick marks the cycles in which CNT may decrement or test for zero.
    logic step_tick;

`ifdef TC_PRESCALE_EN
    localparam logic [7:0] PSC_LAST = 8'(PRESCALE - 1);

    logic [7:0] psc_q, psc_d;

    assign step_tick = (psc_q == PSC_LAST);

    // Prescaler: cleared on LOAD, advances while counting, wraps on its last value.
    always_comb begin
        psc_d = psc_q;
        if (state_q == ST_LOAD) begin
            psc_d = 8'd0;
        end else if ((state_q == ST_CNT) && ctrl_en) begin
            psc_d = step_tick ? 8'd0 : (psc_q + 8'd1);
        end
    end

    // Prescaler register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            psc_q <= 8'd0;
        end else begin
            psc_q <= psc_d;
        end
    end
`else
    assign step_tick = 1'b1;

    logic [31:0] unused_prescale;
    assign unused_prescale = 32'(PRESCALE);
`endif

    // Replace each enabled byte lane of a register, keep the others.
    function automatic logic [31:0] merge_bytes(
        input logic [31:0] old_v,
        input logic [31:0] new_v,
        input logic [3:0]  be
    );
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end
        end
        return res;
    endfunction

    // FSM next state and COUNT update; flag/EN side effects go out as requests.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        fsm_set_flag = 1'b0;
        fsm_clr_flag = 1'b0;
        fsm_clr_en   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (ctrl_en) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                count_d = preset_q;
                state_d = ST_CNT;
            end
            ST_CNT: begin
                if (!ctrl_en) begin
                    state_d = ST_IDLE;
                end else if (step_tick) begin
                    if (count_q == 32'd0) begin
                        state_d      = ST_INT;
                        fsm_set_flag = 1'b1;
                    end else begin
                        count_d = count_q - 32'd1;
                    end
                end
            end
            ST_INT: begin
                if (reload_mode) begin
                    // Auto-reload: the flag lives exactly one cycle.
                    state_d      = ST_LOAD;
                    fsm_clr_flag = 1'b1;
                end else begin
                    // One-shot: stop, keep the flag until software writes CTRL.
                    state_d    = ST_IDLE;
                    fsm_clr_en = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Register file and flag update; a CTRL store overrides the FSM's EN clear,
    // while the FSM raising the flag wins over a same-edge CTRL store.
    always_comb begin
        ctrl_d     = ctrl_q;
        preset_d   = preset_q;
        irq_flag_d = irq_flag_q;

        if (fsm_clr_en) begin
            ctrl_d[0] = 1'b0;
        end
        if (wr_ctrl) begin
            if (byteen[0]) begin
                ctrl_d = wdata[3:0];
            end
            irq_flag_d = 1'b0;
        end
        if (wr_preset) begin
            preset_d = merge_bytes(preset_q, wdata, byteen);
        end
        if (fsm_clr_flag) begin
            irq_flag_d = 1'b0;
        end
        if (fsm_set_flag) begin
            irq_flag_d = 1'b1;
        end

        irq_d = irq_flag_q & ctrl_im;
    end

    // Combinational read mux; outside the window the bus sees zero.
    always_comb begin
        rdata = 32'd0;
        if (hit) begin
            case (addr[3:2])
                OFF_CTRL:   rdata = {28'd0, ctrl_q};
                OFF_PRESET: rdata = preset_q;
                OFF_COUNT:  rdata = count_q;
                OFF_RSVD:   rdata = 32'd0;
                default:    rdata = 32'd0;
            endcase
        end
    end

    // State registers; reset aborts any count in progress.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            ctrl_q     <= 4'd0;
            preset_q   <= 32'd0;
            count_q    <= 32'd0;
            irq_flag_q <= 1'b0;
            irq_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            preset_q   <= preset_d;
            count_q    <= count_d;
            irq_flag_q <= irq_flag_d;
            irq_q      <= irq_d;
        end
    end

    assign irq = irq_q;

endmodule

// File: tb/tb_timer_counter.sv
// tb_timer_counter: self-checking bench for timer_counter.
// Honours TC_PRESCALE_EN the same way as the design (prescale of 4).
module tb_timer_counter;

  localparam logic [31:0] BASE = 32'h0000_7F00;
`ifdef TC_PRESCALE_EN
  localparam int PS = 4;
`else
  localparam int PS = 1;
`endif

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic [3:0]  byteen;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        hit;
  logic        irq;

  always #5 clk = ~clk;

  timer_counter #(.BASE(BASE), .PRESCALE(4)) dut (
    .clk    (clk),
    .reset  (reset),
    .addr   (addr),
    .byteen (byteen),
    .wdata  (wdata),
    .rdata  (rdata),
    .hit    (hit),
    .irq    (irq)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    check(name, {31'd0, act}, {31'd0, exp});
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Store lands on the next rising edge; returns 1 time unit after it.
  task automatic bus_write(input logic [31:0] off, input logic [3:0] be, input logic [31:0] data);
    addr   = BASE + off;
    byteen = be;
    wdata  = data;
    @(posedge clk);
    #1;
    byteen = 4'b0000;
    wdata  = 32'd0;
  endtask

  // Read: expected value queued when the address is driven, popped when rdata settles.
  task automatic check_rd(input string name, input logic [31:0] off, input logic [31:0] exp);
    exp_q.push_back(exp);
    addr   = BASE + off;
    byteen = 4'b0000;
    #1;
    check(name, rdata, exp_q.pop_front());
  endtask

  // ---------------- reference model ----------------
  // Edge (counted from the CTRL store edge) on which INT is entered.
  function automatic int lat(input int p);
    return p * PS + 2 + PS;
  endfunction

  // COUNT after edge k (k >= 2) of a run started with PRESET = p.
  function automatic logic [31:0] cnt_model(input int p, input int k);
    int d;
    d = (k - 2) / PS;
    return (d >= p) ? 32'd0 : 32'(p - d);
  endfunction

  // One-shot run; PRESET is rewritten mid-count to show COUNT ignores it.
  task automatic run_oneshot(input int p, input logic im, input string tag);
    int l;
    l = lat(p);
    bus_write(32'h4, 4'hF, 32'(p));
    bus_write(32'h0, 4'hF, {28'd0, im, 3'b001});
    for (int k = 1; k <= l + 4; k++) begin
      if (k == 3) bus_write(32'h4, 4'hF, 32'd50);
      else step();
      check_bit($sformatf("%s irq k=%0d", tag, k), irq, im && (k >= l + 1));
      if (k >= 2) check_rd($sformatf("%s count k=%0d", tag, k), 32'h8, cnt_model(p, k));
    end
    check_rd({tag, " ctrl after int"}, 32'h0, {28'd0, im, 3'b000});
    check_rd({tag, " preset rewritten"}, 32'h4, 32'd50);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [31:0] wr_off;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd_off;
    logic [31:0] exp_rd;
    logic        exp_hit;
  } vec_t;

  vec_t vecs[13];

  // ---------------- watchdog ----------------
  initial begin
    #1000000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------- main test ----------------
  initial begin
    int l;

    // COUNT is 3 when the table runs (left behind by the auto-reload test).
    vecs[0]  = '{32'h04, 4'hF, 32'h1122_3344, 32'h04, 32'h1122_3344, 1'b1};
    vecs[1]  = '{32'h04, 4'h2, 32'h0000_AB00, 32'h04, 32'h1122_AB44, 1'b1};
    vecs[2]  = '{32'h04, 4'h8, 32'hCC00_0000, 32'h05, 32'hCC22_AB44, 1'b1};
    vecs[3]  = '{32'h00, 4'hF, 32'hFFFF_FFF6, 32'h00, 32'h0000_0006, 1'b1};
    vecs[4]  = '{32'h00, 4'hE, 32'hFFFF_FF00, 32'h00, 32'h0000_0006, 1'b1};
    vecs[5]  = '{32'h08, 4'hF, 32'hDEAD_BEEF, 32'h08, 32'h0000_0003, 1'b1};
    vecs[6]  = '{32'h0C, 4'hF, 32'h1234_5678, 32'h0C, 32'h0000_0000, 1'b1};
    vecs[7]  = '{32'h10, 4'hF, 32'hFFFF_FFFF, 32'h10, 32'h0000_0000, 1'b0};
    vecs[8]  = '{32'h14, 4'hF, 32'h0000_0000, 32'h04, 32'hCC22_AB44, 1'b1};
    vecs[9]  = '{32'h18, 4'hF, 32'h0000_0000, 32'h08, 32'h0000_0003, 1'b1};
    vecs[10] = '{32'hFFFF_FFF4, 4'hF, 32'h0000_0000, 32'hFFFF_FFF4, 32'h0000_0000, 1'b0};
    vecs[11] = '{32'h04, 4'h0, 32'hFFFF_FFFF, 32'h04, 32'hCC22_AB44, 1'b1};
    vecs[12] = '{32'h00, 4'h1, 32'h0000_0000, 32'h00, 32'h0000_0000, 1'b1};

    reset  = 1'b1;
    addr   = BASE;
    byteen = 4'b0000;
    wdata  = 32'd0;
    repeat (2) step();
    reset = 1'b0;
    step();

    // Reset state.
    check_rd("reset ctrl", 32'h0, 32'd0);
    check_rd("reset preset", 32'h4, 32'd0);
    check_rd("reset count", 32'h8, 32'd0);
    check_bit("reset irq", irq, 1'b0);
    check_bit("reset hit", hit, 1'b1);

    // One-shot with interrupt enabled, then software clears it.
    run_oneshot(5, 1'b1, "oneshot");
    bus_write(32'h0, 4'hF, 32'h8);
    check_bit("oneshot irq on clear edge", irq, 1'b1);
    step();
    check_bit("oneshot irq cleared", irq, 1'b0);
    check_rd("oneshot ctrl readback", 32'h0, 32'h8);
    repeat (3) step();
    check_bit("oneshot irq stays clear", irq, 1'b0);

    // Masked one-shot: COUNT still reaches 0, irq never rises.
    run_oneshot(5, 1'b0, "masked");

    // Auto-reload: one-cycle pulse every lat(3) cycles, COUNT reloads to 3.
    l = lat(3);
    bus_write(32'h4, 4'hF, 32'd3);
    bus_write(32'h0, 4'hF, 32'hB);
    for (int k = 1; k <= 3 * l; k++) begin
      step();
      check_bit($sformatf("reload irq k=%0d", k), irq, (k > l) && ((k - 1) % l == 0));
      if ((k >= 2) && ((k - 2) % l == 0)) check_rd($sformatf("reload count k=%0d", k), 32'h8, 32'd3);
    end
    // Now in INT: clear EN on the same edge that sends the FSM back to LOAD.
    bus_write(32'h0, 4'hF, 32'h0);
    check_bit("reload last pulse", irq, 1'b1);
    step();
    check_bit("reload pulse ends", irq, 1'b0);
    repeat (4) step();
    check_rd("reload stop count", 32'h8, 32'd3);
    check_rd("reload stop ctrl", 32'h0, 32'd0);
    check_bit("reload stop irq", irq, 1'b0);

    // Register/decode vectors.
    for (int i = 0; i < 13; i++) begin
      bus_write(vecs[i].wr_off, vecs[i].be, vecs[i].wdata);
      check_rd($sformatf("vec%0d rdata", i), vecs[i].rd_off, vecs[i].exp_rd);
      check_bit($sformatf("vec%0d hit", i), hit, vecs[i].exp_hit);
    end

    // Short one-shot (the prescaled latency case when the macro is defined).
    run_oneshot(2, 1'b1, "p2");

    // PRESET = 0: INT on the first CNT cycle.
    run_oneshot(0, 1'b1, "p0");

    // Reset mid-count: asynchronous, clears everything.
    bus_write(32'h4, 4'hF, 32'd100);
    bus_write(32'h0, 4'hF, 32'h9);
    repeat (10) step();
    check_rd("midrun count", 32'h8, cnt_model(100, 10));
    #3;
    reset = 1'b1;
    check_rd("async reset count", 32'h8, 32'd0);
    #2;
    reset = 1'b0;
    step();
    check_rd("post reset ctrl", 32'h0, 32'd0);
    check_rd("post reset preset", 32'h4, 32'd0);
    check_rd("post reset count", 32'h8, 32'd0);
    check_rd("post reset rsvd", 32'hC, 32'd0);
    check_bit("post reset irq", irq, 1'b0);
    repeat (3) step();
    check_rd("idle after reset count", 32'h8, 32'd0);
    check_bit("idle after reset irq", irq, 1'b0);

    // ---------------- final report ----------------
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
